// File: rtl/aes_dec_pkg.sv
// Shared types, tables and GF(2^8) helpers for the AES-128 inverse cipher core.
// Used by aes_decrypt_core, aes_inv_round and aes_decrypt_core_if.
package aes_dec_pkg;

  localparam int BYTE_W  = 8;
  localparam int WORD_W  = 32;
  localparam int BLOCK_W = 128;
  localparam int BYTES   = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEXP,
    ST_ADDK,
    ST_ROUND,
    ST_FINAL
  } state_e;

  localparam logic [79:0] RCON_TBL = 80'h01_02_04_08_10_20_40_80_1b_36;

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // MSB position of byte i in a block; byte 0 sits at [127:120].
  function automatic int byte_msb(input int i);
    return BLOCK_W - 1 - BYTE_W * i;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{~b, 3'b000} +: BYTE_W];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_TBL[{~b, 3'b000} +: BYTE_W];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    v = 8'h00;
    for (int i = 1; i <= 10; i++)
      if (r == 4'(i)) v = RCON_TBL[BYTE_W*(10-i) +: BYTE_W];
    return v;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  // Round key r -> r+1.
  function automatic logic [127:0] key_fwd_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Round key r -> r-1, where rc is Rcon[r].
  function automatic logic [127:0] key_inv_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0] ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_word(rot_word(w3)) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_decrypt_core_if.sv
// Start/valid bus of the AES-128 inverse cipher core; slave = core side.
interface aes_decrypt_core_if;
  import aes_dec_pkg::*;

  logic               AES_en;
  logic [BLOCK_W-1:0] AES_data_in;
  logic [BLOCK_W-1:0] AES_key_in;
  logic [BLOCK_W-1:0] AES_data_out;
  logic               AES_data_out_valid;
  logic               AES_busy;

  modport master (
    output AES_en, AES_data_in, AES_key_in,
    input  AES_data_out, AES_data_out_valid, AES_busy
  );

  modport slave (
    input  AES_en, AES_data_in, AES_key_in,
    output AES_data_out, AES_data_out_valid, AES_busy
  );
endinterface

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless last_i is set (final round).
module aes_inv_round
  import aes_dec_pkg::*;
(
  input  logic [BLOCK_W-1:0] state_i,
  input  logic [BLOCK_W-1:0] rkey_i,
  input  logic               last_i,
  output logic [BLOCK_W-1:0] state_o
);

  logic [BLOCK_W-1:0] shifted;
  logic [BLOCK_W-1:0] keyed;

  // Byte index is 4*col + row; row r rotates right by r columns.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    shifted = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        shifted[byte_msb(4*c + r) -: BYTE_W] = state_i[byte_msb(4*((c - r) & 3) + r) -: BYTE_W];
  end

  always_comb begin
    keyed = '0;
    for (int i = 0; i < BYTES; i++)
      keyed[byte_msb(i) -: BYTE_W] = inv_sbox(shifted[byte_msb(i) -: BYTE_W]);
    keyed = keyed ^ rkey_i;
  end

  assign state_o = last_i ? keyed
                          : {inv_mix_col(keyed[127:96]), inv_mix_col(keyed[95:64]),
                             inv_mix_col(keyed[63:32]),  inv_mix_col(keyed[31:0])};

endmodule

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 inverse cipher, 21-cycle latency, on-the-fly reverse key schedule.
// Optional key cache (k10 reuse, 11-cycle latency) enabled by `AES_DEC_KEY_CACHE_EN.
module aes_decrypt_core
  import aes_dec_pkg::*;
(
  input logic               AES_clk,
  input logic               AES_rst_n,
  aes_decrypt_core_if.slave bus
);

  state_e             state_q, state_d;
  logic [3:0]         rnd_q, rnd_d;
  logic               en_q, en_d;
  logic               arm_q, arm_d;
  logic [BLOCK_W-1:0] s_q, s_d;
  logic [BLOCK_W-1:0] key_q, key_d;
  logic [BLOCK_W-1:0] out_q, out_d;
  logic               valid_q, valid_d;
  logic [BLOCK_W-1:0] round_out;
  logic               start;

`ifdef AES_DEC_KEY_CACHE_EN
  logic [BLOCK_W-1:0] cache_key_q, cache_key_d;
  logic [BLOCK_W-1:0] cache_k10_q, cache_k10_d;
  logic               cache_vld_q, cache_vld_d;
`endif

  aes_inv_round u_round (
    .state_i (s_q),
    .rkey_i  (key_q),
    .last_i  (state_q == ST_FINAL),
    .state_o (round_out)
  );

  // arm_q blocks a start on the first edge after reset so a level already high is not an edge.
  assign start = bus.AES_en & ~en_q & arm_q;

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    s_d     = s_q;
    key_d   = key_q;
    out_d   = out_q;
    valid_d = 1'b0;
    en_d    = bus.AES_en;
    arm_d   = 1'b1;
`ifdef AES_DEC_KEY_CACHE_EN
    cache_key_d = cache_key_q;
    cache_k10_d = cache_k10_q;
    cache_vld_d = cache_vld_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          s_d     = bus.AES_data_in;
          key_d   = bus.AES_key_in;
          rnd_d   = 4'd1;
          state_d = ST_KEXP;
`ifdef AES_DEC_KEY_CACHE_EN
          if (cache_vld_q && (bus.AES_key_in == cache_key_q)) begin
            key_d   = cache_k10_q;
            state_d = ST_ADDK;
          end
`endif
        end
      end
      ST_KEXP: begin
        key_d = key_fwd_step(key_q, rcon(rnd_q));
        if (rnd_q == 4'd10) state_d = ST_ADDK;
        else                rnd_d   = rnd_q + 4'd1;
      end
      ST_ADDK: begin
        s_d     = s_q ^ key_q;
        key_d   = key_inv_step(key_q, rcon(4'd10));
        rnd_d   = 4'd9;
        state_d = ST_ROUND;
`ifdef AES_DEC_KEY_CACHE_EN
        cache_k10_d = key_q;
        cache_vld_d = 1'b0;
`endif
      end
      ST_ROUND: begin
        s_d   = round_out;
        key_d = key_inv_step(key_q, rcon(rnd_q));
        if (rnd_q == 4'd1) begin
          rnd_d   = 4'd0;
          state_d = ST_FINAL;
        end else begin
          rnd_d = rnd_q - 4'd1;
        end
      end
      ST_FINAL: begin
        out_d   = round_out;
        valid_d = 1'b1;
        state_d = ST_IDLE;
`ifdef AES_DEC_KEY_CACHE_EN
        // key_q has walked back to k0, which is the cipher key itself.
        cache_key_d = key_q;
        cache_vld_d = 1'b1;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge AES_clk) begin
    if (!AES_rst_n) begin
      state_q <= ST_IDLE;
      rnd_q   <= '0;
      en_q    <= 1'b0;
      arm_q   <= 1'b0;
      // NOTE: datapath registers are reset too, so the output bus reads zero after reset.
      s_q     <= '0;
      key_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      en_q    <= en_d;
      arm_q   <= arm_d;
      s_q     <= s_d;
      key_q   <= key_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

`ifdef AES_DEC_KEY_CACHE_EN
  always_ff @(posedge AES_clk) begin
    if (!AES_rst_n) begin
      cache_key_q <= '0;
      cache_k10_q <= '0;
      cache_vld_q <= 1'b0;
    end else begin
      cache_key_q <= cache_key_d;
      cache_k10_q <= cache_k10_d;
      cache_vld_q <= cache_vld_d;
    end
  end
`endif

  assign bus.AES_data_out       = out_q;
  assign bus.AES_data_out_valid = valid_q;
  assign bus.AES_busy           = (state_q != ST_IDLE) | valid_q;

endmodule

// File: doc/aes_decrypt_core.md
# aes_decrypt_core

Iterative AES-128 inverse cipher: accepts a 128-bit ciphertext and 128-bit cipher key, and returns the plaintext after a fixed-latency run of ten inverse rounds. It is the receive-side counterpart of `AES_top` and is driven with the same start/valid protocol, so the two cores can be chained encrypt→decrypt in one bench. Round keys are produced on the fly: a forward expansion runs to round key 10, then the schedule is walked backwards during decryption.

## Interface
- No parameters (AES-128 only; Nk=4, Nr=10 fixed).
- `AES_clk` input 1: single clock, rising edge.
- `AES_rst_n` input 1: synchronous active-low reset.
- `AES_en` input 1: start request; a 0→1 transition starts an operation.
- `AES_data_in` input 128: ciphertext; byte 0 = bits [127:120], column-major state (FIPS-197 order).
- `AES_key_in` input 128: cipher key, same byte order.
- `AES_data_out` output 128: plaintext, held until the next completion.
- `AES_data_out_valid` output 1: one-cycle pulse when `AES_data_out` updates.
- `AES_busy` output 1: high from the capture edge until the cycle `AES_data_out_valid` pulses, inclusive.

## Operation
- Registered `en_q` tracks `AES_en`. A start is `AES_en & ~en_q` while in IDLE.
- A start captures `AES_data_in` and `AES_key_in` on the same edge. Later input changes are ignored until IDLE.
- Holding `AES_en` high does not retrigger. A rising edge while busy is dropped, not queued.
- FSM states:
  - IDLE: wait for start. On start, go to KEXP with `rnd`=1.
  - KEXP: forward key expansion, `w ← w ^ f(w, Rcon[rnd])`. Runs 10 cycles (`rnd` 1..10), then goes to ADDK.
  - ADDK: `s ← ct ^ k10`. The key register steps back to k9. Set `rnd`=9 and go to ROUND.
  - ROUND: `s ← InvMixColumns(InvSubBytes(InvShiftRows(s)) ^ k_rnd)`. The key steps back one round per cycle. `rnd` counts down 9..1, then FINAL.
  - FINAL: `AES_data_out ← InvSubBytes(InvShiftRows(s)) ^ k0`. Pulse valid, then IDLE.
- Inverse key step: `w'[j] = w[j] ^ w[j-1]` for j=3..1; `w'[0] = w[0] ^ SubWord(RotWord(w'[3])) ^ Rcon[r]`.
- All GF(2^8) arithmetic uses the polynomial 0x11B. Rcon is 01,02,04,08,10,20,40,80,1B,36.
- Reset (sync, `AES_rst_n`=0 at an edge), including mid-operation:
  - FSM → IDLE; `rnd`, `en_q`, state and key registers → 0.
  - `AES_data_out` → 128'h0; `AES_data_out_valid` → 0; `AES_busy` → 0.
  - An `AES_en` already high when reset releases is not a start: `en_q` samples it first. A fresh 0→1 edge is required.

## Timing
- E0 = capture edge. KEXP occupies E1–E10, ADDK is E11, ROUND is E12–E20, FINAL is E21.
- `AES_data_out` and `AES_data_out_valid`=1 are visible after E21, so latency is 21 cycles.
- `AES_busy` is high after E0 through the cycle after E21.
- Back-to-back: the earliest next start is an `AES_en` 0→1 sampled at E22. The valid pulse and the next capture may then be on adjacent edges.
- Throughput is at most one block per 22 cycles.
- Exactly one S-box/inverse S-box datapath level and one InvMixColumns level exist between registers.

## Configuration
- `AES_DEC_KEY_CACHE_EN` defined:
  - FINAL stores the cipher key and its k10 in a cache.
  - A start whose `AES_key_in` equals the cached key with the cache valid skips KEXP: E1 is ADDK, and valid is visible after E11 (latency 11).
  - Reset invalidates the cache.
- Undefined: no cache; latency is always 21 cycles.

## Structure
- Package `aes_dec_pkg` holds:
  - FSM state enum; Rcon table.
  - `sbox` and `inv_sbox` functions; `xtime` and `gmul` helpers.
  - Byte/word slicing constants.
- Sub-module `aes_inv_round` is purely combinational: state, round key and a `last` flag in, next state out. The top holds the FSM, counters, key schedule and the optional cache.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a → after 21 cycles valid pulses once with out 00112233445566778899aabbccddeeff.
- FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 → out 3243f6a8885a308d313198a2e0370734.
- `AES_en` held high for 60 cycles, with `AES_data_in` changed at cycles 5 and 30 → exactly one valid pulse, result from the ciphertext captured at E0.
- `AES_rst_n` low for one edge at cycle 10 of a run → outputs 0 and `AES_busy` 0 next cycle, no valid pulse. A new edge then gives correct C.1 plaintext.
- Loopback: `AES_top` encrypts 00000000_00000000_00000000_0000004e under key aa2bdb40bff6a5e8caa9ba3ebc1e2acc, and its output feeds this core → plaintext restored bit-exact.
- With `AES_DEC_KEY_CACHE_EN`: run C.1 twice → the second run is valid after 11 cycles with the same output. A third run with the B key takes 21 cycles.
